// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//   Exhaustive truth-table checker for small combinational gates. It walks
//   every input vector onto a device under test, waits a fixed settle time,
//   samples the DUT response and compares it with a parameterised expected
//   table. At the end it reports pass/fail, a mismatch count and the index of
//   the first failing vector.
//
// Parameters
//   N_IN     DUT input count (1..4)
//   N_OUT    DUT output count (1..4)
//   SETTLE   cycles between a vector change and its sample (1..15)
//   EXPECTED expected table; entry k is EXPECTED[k*N_OUT +: N_OUT]
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      single-cycle sweep request (ignored while busy)
//   vec_o      stimulus vector driven onto the DUT inputs
//   resp_i     DUT outputs, assumed synchronous to clk
//   busy       high while a sweep is in progress
//   done       high from sweep completion until the next accepted start/reset
//   pass       valid while done; 1 when no vector mismatched
//   err_count  number of mismatching vectors
//   fail_idx   index of the first mismatching vector
//   fail_vld   high once any mismatch has been recorded
//
// Build option
//   TT_SWEEP_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
//                             with vec_o left on the failing vector.
module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 2,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec_o,
  input  logic [N_OUT-1:0]  resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   fail_idx,
  output logic              fail_vld
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // SETTLE is at most 15, so a 4-bit down-counter covers every legal value.
  localparam int             CW        = 4;
  localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  logic [1:0]       state;
  logic [N_IN-1:0]  idx;
  logic [CW-1:0]    cnt;

  logic [31:0]      ent_base;
  logic [N_OUT-1:0] exp_ent;
  logic             mismatch;
  logic [N_IN:0]    err_next;

  // The stimulus vector is the sweep index itself: it only moves on the edge
  // that enters SETTLE, so it is stable through the whole settle and check.
  assign vec_o = idx;

  // Expected entry for the vector currently on the DUT.
  assign ent_base = 32'(idx) * 32'(N_OUT);
  assign exp_ent  = EXPECTED[ent_base +: N_OUT];
  assign mismatch = (resp_i != exp_ent);
  // Count including the vector being checked this cycle; used both for the
  // register update and for the final pass decision on the same edge.
  assign err_next = err_count + (N_IN+1)'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      fail_vld  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= '0;
            fail_idx  <= '0;
            fail_vld  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            idx       <= '0;
            cnt       <= SETTLE_LD;
            busy      <= 1'b1;
            state     <= S_SETTLE;
          end
        end

        // Counter holds the cycles still to wait; reaching zero means the
        // SETTLE-th cycle is ending, so the next cycle samples.
        S_SETTLE: begin
          if (cnt == '0) state <= S_CHECK;
          else           cnt   <= cnt - 1'b1;
        end

        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && !fail_vld) begin
            fail_idx <= idx;
            fail_vld <= 1'b1;
          end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
          if (mismatch || idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx   <= idx + 1'b1;
            cnt   <= SETTLE_LD;
            state <= S_SETTLE;
          end
`else
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx   <= idx + 1'b1;
            cnt   <= SETTLE_LD;
            state <= S_SETTLE;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default instance: and3 table, N_IN=3, SETTLE=2.
  logic       start;
  logic [2:0] vec;
  logic [0:0] resp;
  logic       busy, done, pass, fail_vld;
  logic [3:0] err_count;
  logic [2:0] fail_idx;
  int         mode;   // 0 loopback, 1 inverted, 2 loopback with vec 5 forced to 1

  always_comb begin
    case (mode)
      1:       resp = ~(&vec);
      2:       resp = (vec == 3'd5) ? 1'b1 : (&vec);
      default: resp = &vec;
    endcase
  end

  tt_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .vec_o(vec), .resp_i(resp),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_idx(fail_idx), .fail_vld(fail_vld)
  );

  // Half-adder instance: {carry,sum}.
  logic       start2;
  logic [1:0] vec2;
  logic [1:0] resp2;
  logic       busy2, done2, pass2, fail_vld2;
  logic [2:0] err_count2;
  logic [1:0] fail_idx2;

  assign resp2 = {vec2[1] & vec2[0], vec2[1] ^ vec2[0]};

  tt_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(1), .EXPECTED(8'b10_01_01_00)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .vec_o(vec2), .resp_i(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_idx(fail_idx2), .fail_vld(fail_vld2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start is captured at the posedge between the two negedges; returns at the
  // negedge just after that start edge.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Counts cycles (sampled at negedge) from the start edge until done rises.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int guard;
  bit pulsed;

  initial begin
    start = 1'b0;
    start2 = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_vec", vec, 0);
    chk("rst_fvld", fail_vld, 0);
    chk("rst_fidx", fail_idx, 0);
    chk("rst_done2", done2, 0);
    @(negedge clk) rst = 1'b0;

    // 1. and3 loopback: clean sweep, done after 24 cycles
    mode = 0;
    pulse_start();
    chk("t1_busy_after_E0", busy, 1);
    chk("t1_vec_after_E0", vec, 0);
    wait_done(n);
    chk("t1_latency", n, 24);
    chk("t1_busy_low", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_fvld", fail_vld, 0);

    // 2. inverted response: every vector mismatches
    mode = 1;
    pulse_start();
    chk("t2_done_cleared", done, 0);
    wait_done(n);
    chk("t2_latency", n, 24);
    chk("t2_err", err_count, 8);
    chk("t2_pass", pass, 0);
    chk("t2_fidx", fail_idx, 0);
    chk("t2_fvld", fail_vld, 1);

    // 3. single fault at vector 5
    mode = 2;
    pulse_start();
    wait_done(n);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    chk("t3_latency", n, 18);
    chk("t3_vec_held", vec, 5);
`else
    chk("t3_latency", n, 24);
`endif
    chk("t3_err", err_count, 1);
    chk("t3_fidx", fail_idx, 5);
    chk("t3_fvld", fail_vld, 1);
    chk("t3_pass", pass, 0);

    // 4. half adder, SETTLE=1: 4 vectors x 2 cycles
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_latency", n, 8);
    chk("t4_pass", pass2, 1);
    chk("t4_err", err_count2, 0);

    // 5. start re-pulsed mid-sweep at vec 3 and during the final CHECK
    mode = 0;
    pulse_start();
    n = 0;
    pulsed = 0;
    while (!done && n < 200) begin
      start = (!pulsed && vec == 3'd3) || (n == 23);
      if (vec == 3'd3) pulsed = 1;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("t5_repulse_seen", pulsed, 1);
    chk("t5_latency", n, 24);
    chk("t5_pass", pass, 1);
    chk("t5_err", err_count, 0);
    @(negedge clk);
    chk("t5_no_restart_busy", busy, 0);
    chk("t5_done_held", done, 1);

    // 6. async reset mid-sweep at idx 4 (with errors already counted)
    mode = 1;
    pulse_start();
    guard = 0;
    while (vec != 3'd4 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_reached_idx4", vec, 4);
    chk("t6_err_before_rst", err_count, 4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err_count, 0);
    chk("t6_rst_vec", vec, 0);
    chk("t6_rst_fvld", fail_vld, 0);
    @(negedge clk) rst = 1'b0;
    mode = 0;
    pulse_start();
    wait_done(n);
    chk("t6_after_latency", n, 24);
    chk("t6_after_pass", pass, 1);
    chk("t6_after_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
